// File: rtl/alu_pipe.sv
// Registered 16-op ALU with valid/ready on both sides and a single output register.
// Define ALU_MUL_EN to add opcode 0x10, an iterative unsigned shift-add multiply.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_OutHi,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic             out_free, ld_single;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
  logic             c_q, c_d, z_q, z_d, v_q, v_d, ill_q, ill_d;

  assign out_free = !out_valid_q || out_ready;
  assign add_w    = {1'b0, A} + {1'b0, B};
  assign sub_w    = {1'b0, A} - {1'b0, B};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (ALU_Sel)
      5'h00: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      5'h01: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      5'h02: alu_res = A & B;
      5'h03: alu_res = A | B;
      5'h04: alu_res = A ^ B;
      5'h05: alu_res = ~(A | B);
      5'h06: begin alu_res = {A[WIDTH-2:0], 1'b0}; alu_c = A[WIDTH-1]; end
      5'h07: begin alu_res = {1'b0, A[WIDTH-1:1]}; alu_c = A[0]; end
      5'h08: alu_res = ~(A & B);
      5'h09: alu_res = ~(A ^ B);
      5'h0A: alu_res = WIDTH'(A <  B);
      5'h0B: alu_res = WIDTH'(A == B);
      5'h0C: alu_res = WIDTH'(A >  B);
      5'h0D: alu_res = WIDTH'(A != B);
      5'h0E: alu_res = WIDTH'(A >= B);
      5'h0F: alu_res = WIDTH'(A <= B);
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [WIDTH:0]     sum;
  logic               ld_mul;

  assign in_ready = (state_q == IDLE) && out_free;

  // Low half starts as the multiplier and is shifted out as the product fills in.
  assign sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    ld_single = 1'b0;
    ld_mul    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (ALU_Sel == 5'h10) begin
            state_d = MUL_BUSY;
            cnt_d   = '0;
            mcand_d = A;
            prod_d  = {{WIDTH{1'b0}}, B};
          end else begin
            ld_single = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        if (cnt_q != CW'(WIDTH - 1)) begin
          prod_d = prod_step;
          cnt_d  = cnt_q + CW'(1);
        end else if (out_free) begin
          // final step only completes once the output register can take it
          prod_d  = prod_step;
          ld_mul  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end
`else
  assign in_ready  = out_free;
  assign ld_single = in_valid && in_ready;
`endif

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_d       = out_q;
    hi_d        = hi_q;
    c_d         = c_q;
    z_d         = z_q;
    v_d         = v_q;
    ill_d       = ill_q;
    if (ld_single) begin
      out_valid_d = 1'b1;
      out_d       = alu_res;
      hi_d        = '0;
      c_d         = alu_c;
      z_d         = (alu_res == '0);
      v_d         = alu_v;
      ill_d       = alu_ill;
    end
`ifdef ALU_MUL_EN
    if (ld_mul) begin
      out_valid_d = 1'b1;
      out_d       = prod_step[WIDTH-1:0];
      hi_d        = prod_step[2*WIDTH-1:WIDTH];
      c_d         = 1'b0;
      z_d         = (prod_step == '0);
      v_d         = (prod_step[2*WIDTH-1:WIDTH] != '0);
      ill_d       = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      hi_q        <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      hi_q        <= hi_d;
      c_q         <= c_d;
      z_q         <= z_d;
      v_q         <= v_d;
      ill_q       <= ill_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALU_Out   = out_q;
  assign ALU_OutHi = hi_q;
  assign CarryOut  = c_q;
  assign Zero      = z_q;
  assign Overflow  = v_q;
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: random and directed ops against an arithmetic model.
module tb_alu_pipe;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic CarryOut, Zero, Overflow, Illegal;
  logic [W-1:0] A, B, ALU_Out, ALU_OutHi;
  logic [4:0] ALU_Sel;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .ALU_OutHi(ALU_OutHi), .CarryOut(CarryOut), .Zero(Zero),
    .Overflow(Overflow), .Illegal(Illegal)
  );

  typedef struct {int out; int hi; bit c; bit z; bit v; bit ill; int acc; int lat;} exp_t;
  exp_t sbq[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit mul_pend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: results from integer arithmetic on the operand values.
  function automatic exp_t model(int a, int b, int sel);
    exp_t e;
    int sa, sb, t, p;
    sa = (a >= M/2) ? a - M : a;
    sb = (b >= M/2) ? b - M : b;
    e.out = 0; e.hi = 0; e.c = 0; e.z = 0; e.v = 0; e.ill = 0; e.acc = 0; e.lat = 0;
    case (sel)
      0:  begin t = a + b; e.out = t % M; e.c = (t >= M);
                t = sa + sb; e.v = (t < -M/2) || (t >= M/2); end
      1:  begin e.out = (a - b + M) % M; e.c = (a < b);
                t = sa - sb; e.v = (t < -M/2) || (t >= M/2); end
      2:  e.out = a & b;
      3:  e.out = a | b;
      4:  e.out = a ^ b;
      5:  e.out = ~(a | b) & (M - 1);
      6:  begin e.out = (a * 2) % M; e.c = (a >= M/2); end
      7:  begin e.out = a / 2; e.c = (a % 2 == 1); end
      8:  e.out = ~(a & b) & (M - 1);
      9:  e.out = ~(a ^ b) & (M - 1);
      10: e.out = int'(a < b);
      11: e.out = int'(a == b);
      12: e.out = int'(a > b);
      13: e.out = int'(a != b);
      14: e.out = int'(a >= b);
      15: e.out = int'(a <= b);
`ifdef ALU_MUL_EN
      16: begin p = a * b; e.out = p % M; e.hi = p / M; e.v = (e.hi != 0); e.lat = W; end
`endif
      default: e.ill = 1;
    endcase
    e.z = (e.out == 0) && (e.hi == 0);
    return e;
  endfunction

  // Monitor: latency on first appearance, hold under backpressure, compare on handoff.
  bit pv = 0, pr = 0;
  logic [2*W+3:0] pcur;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 0;
      pr = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(out_valid), 1);
        if (out_valid)
          chk("hold_data", int'({ALU_OutHi, ALU_Out, CarryOut, Zero, Overflow, Illegal}), int'(pcur));
      end else if (out_valid) begin
        if (sbq.size() == 0) fail_now("unexpected_result");
        else begin
          chk("latency", cyc - sbq[0].acc, sbq[0].lat);
          if (sbq[0].lat != 0) mul_pend = 0;
        end
      end
      if (out_valid && out_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("ALU_Out", int'(ALU_Out), e.out);
        chk("ALU_OutHi", int'(ALU_OutHi), e.hi);
        chk("CarryOut", int'(CarryOut), int'(e.c));
        chk("Zero", int'(Zero), int'(e.z));
        chk("Overflow", int'(Overflow), int'(e.v));
        chk("Illegal", int'(Illegal), int'(e.ill));
      end
      chk("in_ready", int'(in_ready), int'(!mul_pend && (!out_valid || out_ready)));
      pv = out_valid;
      pr = out_ready;
      pcur = {ALU_OutHi, ALU_Out, CarryOut, Zero, Overflow, Illegal};
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(bit v, int a, int b, int sel, bit ordy, output bit acc);
    exp_t e;
    in_valid = v; A = W'(a); B = W'(b); ALU_Sel = 5'(sel); out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      e = model(a, b, sel);
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    if (acc && e.lat != 0) mul_pend = 1;
    in_valid = 0;
  endtask

  task automatic issue(int a, int b, int sel);
    bit acc = 0;
    for (int i = 0; i < 50 && !acc; i++) drive(1, a, b, sel, 1, acc);
    if (!acc) fail_now("issue_timeout");
  endtask

  task automatic idle(int n, bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, ordy, acc);
  endtask

  task automatic drain();
    int i = 0;
    while ((sbq.size() != 0 || mul_pend) && i < 100) begin idle(1, 1); i++; end
    if (sbq.size() != 0 || mul_pend) fail_now("drain_timeout");
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ALU_Out", int'(ALU_Out), 0);
    chk("rst_ALU_OutHi", int'(ALU_OutHi), 0);
    chk("rst_flags", int'({CarryOut, Zero, Overflow, Illegal}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int a, b, sel;
    rst = 1; in_valid = 0; out_ready = 1; A = '0; B = '0; ALU_Sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 0;

    // Directed values and one of every opcode.
    issue(8'hAA, 8'h55, 5'h00);
    issue(8'hAA, 8'h55, 5'h01);
    issue(8'hFF, 8'h01, 5'h00);
    issue(8'h81, 8'h00, 5'h06);
    issue(8'hAA, 8'h55, 5'h0A);
    issue(8'hAA, 8'h55, 5'h0E);
    issue(8'h7F, 8'h01, 5'h00);
    issue(8'h80, 8'h01, 5'h01);
    issue(8'h00, 8'h01, 5'h01);
    issue(8'h81, 8'h00, 5'h07);
    issue(8'h12, 8'h34, 5'h10);
    issue(8'h12, 8'h34, 5'h1F);
    for (int s = 2; s < 16; s++) issue(8'hC3, 8'h5A, s);
    drain();

    // Backpressure: hold a result, then release with a new op on the same edge.
    issue(8'h10, 8'h20, 5'h00);
    idle(3, 0);
    drive(1, 8'h33, 8'h0F, 5'h04, 1, acc);
    if (!acc) fail_now("bp_accept");
    drain();

`ifdef ALU_MUL_EN
    issue(8'hAA, 8'h55, 5'h10);
    drain();
    issue(8'h00, 8'h37, 5'h10);
    issue(8'hFF, 8'hFF, 5'h10);
    drain();
    issue(8'hAA, 8'h55, 5'h10);
    drain();
    // Abort a multiply in its fourth busy cycle.
    issue(8'h12, 8'h34, 5'h10);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk_reset_outputs();
    sbq.delete();
    mul_pend = 0;
    @(posedge clk); #1;
    rst = 0;
    idle(W + 3, 1);
    issue(8'h01, 8'h01, 5'h00);
    drain();
`endif

    // Random phase with corner operands and random backpressure.
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 4) == 0) ? ($urandom_range(0, 1) ? M - 1 : M / 2) : $urandom_range(0, M - 1);
      b = ($urandom_range(0, 4) == 0) ? ($urandom_range(0, 1) ? 0 : M / 2 - 1) : $urandom_range(0, M - 1);
      sel = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) sel = 16;
      drive($urandom_range(0, 3) != 0, a, b, sel, $urandom_range(0, 2) != 0, acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the 8-bit combinational ALU. Same 16-op map at generic WIDTH, with a valid/ready handshake on input and output and a single output register. Adds an optional iterative multiply. Sits between the operand-fetch stage and the writeback stage of the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operands/op presented
in_ready  output  1  block accepts the op this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
ALU_Sel  input  5  opcode
out_valid  output  1  result register holds a valid result
out_ready  input  1  consumer takes the result this cycle
ALU_Out  output  WIDTH  result (for MUL: product low half)
ALU_OutHi  output  WIDTH  product high half for MUL; 0 for all other ops
CarryOut  output  1  carry/borrow/shifted-out bit
Zero  output  1  result == 0 (MUL: full 2*WIDTH product == 0)
Overflow  output  1  signed overflow; MUL: high half nonzero
Illegal  output  1  opcode unsupported

Behaviour:
- Reset (async, rst=1): out_valid=0, ALU_Out=0, ALU_OutHi=0, CarryOut=0, Zero=0, Overflow=0, Illegal=0; FSM -> IDLE. Reset mid-MUL aborts the op; no result is produced.
- Accept: transfer when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output: result held stable while out_valid && !out_ready. out_valid clears on out_ready unless a new result loads in the same edge.
- Single-cycle ops: accepted at edge N; result/flags registered at N; out_valid high in cycle N+1. Back-to-back throughput is 1/cycle when out_ready=1.
- Opcodes (unsigned unless noted): 0x00 ADD, 0x01 SUB (A-B), 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 NOR, 0x06 SHL by 1, 0x07 SHR by 1 (logical), 0x08 NAND, 0x09 XNOR, 0x0A LT, 0x0B EQ, 0x0C GT, 0x0D NE, 0x0E GE, 0x0F LE, 0x10 MUL (optional feature), 0x11-0x1F reserved.
- Compare ops: ALU_Out = {WIDTH-1 zeros, result bit}.
- CarryOut:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (A<B).
  - SHL: A[WIDTH-1].
  - SHR: A[0].
  - All other ops: 0.
- Overflow:
  - ADD/SUB: two's-complement signed overflow.
  - All other ops: 0.
- Reserved opcode: ALU_Out=0, ALU_OutHi=0, Zero=1, Illegal=1, other flags 0; single-cycle latency.
- FSM: IDLE, MUL_BUSY.
  - IDLE -> MUL_BUSY on accepting opcode 0x10 (feature enabled).
  - MUL_BUSY: one shift-add step per cycle using an internal iteration counter, 0..WIDTH-1.
  - MUL_BUSY -> IDLE at the edge ending step WIDTH-1; the product is loaded into the output register at that same edge.
  - MUL latency: accepted at edge N, out_valid in cycle N+WIDTH+1. in_ready=0 throughout MUL_BUSY.
  - Output register: MUL is only accepted with the output register free or draining. A pending result must drain before MUL completes; the MUL stalls in its last step until !out_valid || out_ready.
- Operands are captured at accept; later changes to A, B or ALU_Sel do not affect an op in flight.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Opcode 0x10 is an unsigned WIDTH x WIDTH iterative multiply.
  - Result: {ALU_OutHi, ALU_Out} = A*B.
  - Flags: Overflow = (ALU_OutHi != 0); CarryOut = 0.
- Undefined:
  - Opcode 0x10 is handled as reserved (Illegal=1, 1-cycle).
  - No MUL_BUSY state or iteration counter is synthesised; in_ready depends only on the output register.

Test Plan:
- WIDTH=8, out_ready=1; ADD A=0xAA, B=0x55 -> out_valid one cycle after accept; ALU_Out=0xFF, C=0, Z=0, V=0. Then SUB -> 0x55, C=0, V=1.
- ADD A=0xFF, B=0x01 -> ALU_Out=0x00, C=1, Z=1, V=0. SHL A=0x81 -> 0x02, C=1. LT A=0xAA, B=0x55 -> 0x00. GE -> 0x01.
- Backpressure: out_ready=0 after a result -> ALU_Out/flags held, in_ready=0. Raise out_ready with in_valid=1 -> next result loads at the same edge; no drop, no duplicate.
- ALU_MUL_EN defined; MUL A=0xAA, B=0x55 -> out_valid 9 cycles after accept; ALU_OutHi=0x38, ALU_Out=0x72, Overflow=1, Zero=0; in_ready=0 while busy. MUL 0x00 x 0x37 -> Zero=1.
- Assert rst in MUL_BUSY cycle 4 -> all outputs 0 immediately, out_valid stays 0 after release. Next ADD 0x01+0x01 -> 0x02 in 1 cycle.
- ALU_MUL_EN undefined; ALU_Sel=0x10 or 0x1F -> 1-cycle result 0, Illegal=1, Zero=1, C=V=0.
